scan_chain_driver: RTL and testbench

//   Drives one scan chain built from sdffrnq-style scan flops: loads a parallel pattern, serially shifts it
//   in on SE/SI, pulses one functional capture cycle, then shifts the chain out via SO into a parallel

---
 rtl/scan_chain_driver_pkg.sv | 18 +
 rtl/scan_chain_driver_shreg.sv | 30 +++
 rtl/scan_chain_driver.sv | 127 ++++++++++++
 tb/tb_scan_chain_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/scan_chain_driver_pkg.sv
// Shared types and helpers for the scan chain driver.
//   state_t   : sequencer state encoding (3-bit)
//   cnt_width : width of the per-phase edge counter for a chain of n flops
package scan_chain_driver_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_chain_driver_shreg.sv
// N-bit register with parallel load and serial right shift.
//   clk, rst_n : clock, asynchronous active-low reset (clears to zero)
//   load, din  : parallel load (has priority over shift)
//   shift, sin : right shift, sin enters the MSB, LSB falls out
//   q          : parallel view; q[0] is the serial output
module scan_chain_driver_shreg
  import scan_chain_driver_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/scan_chain_driver.sv
// Scan chain driver: loads a parallel pattern, shifts it into the chain,
// pulses one functional capture cycle, then shifts the chain out into a
// parallel response register.
//   CLK, RN  : clock (shared with the chain), async active-low reset
//   start    : sequence request, sampled only in IDLE
//   pattern  : stimulus; pattern[i] ends in the flop i positions from the tail
//   SE, SI   : scan enable / serial data to the chain head (registered)
//   SO       : Q of the chain tail flop
//   response : captured chain contents; response[i] = flop i from the tail
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse when response becomes valid
//   parity   : XOR of response when SCAN_CHAIN_DRIVER_PARITY_EN is defined,
//              otherwise tied low
module scan_chain_driver
  import scan_chain_driver_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 16
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 busy,
  output logic                 done,
  output logic                 parity
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN);

  state_t          state, next_state;
  logic [CW-1:0]   cnt_q;
  logic            last;
  logic            se_d, busy_d, done_d;
  logic [CHAIN_LEN-1:0] stim_q;
  logic            stim_unused;

  assign last = (cnt_q == CW'(CHAIN_LEN - 1));

  // State register plus registered outputs
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      SE    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      SE    <= se_d;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (start) next_state = SHIFT_IN;
      SHIFT_IN:  if (last)  next_state = CAPTURE;
      CAPTURE:              next_state = SHIFT_OUT;
      SHIFT_OUT: if (last)  next_state = DONE;
      DONE:                 next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so the flops present them in the
  // same cycle the FSM enters the corresponding state.
  always_comb begin
    se_d   = (next_state == SHIFT_IN) || (next_state == SHIFT_OUT);
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      cnt_q <= '0;
    end else if (next_state != state) begin
      cnt_q <= '0;
    end else if (state == SHIFT_IN || state == SHIFT_OUT) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // SI is taken straight from the stimulus LSB flop. Zeros shift in behind
  // the pattern, so the register is empty (SI=0) outside SHIFT_IN.
  scan_chain_driver_shreg #(.WIDTH(CHAIN_LEN)) u_stim (
    .clk   (CLK),
    .rst_n (RN),
    .load  (state == IDLE && start),
    .din   (pattern),
    .shift (state == SHIFT_IN),
    .sin   (1'b0),
    .q     (stim_q)
  );

  assign SI = stim_q[0];
  // Upper stimulus bits only feed the shift path inside the register.
  assign stim_unused = ^stim_q[CHAIN_LEN-1:1];

  scan_chain_driver_shreg #(.WIDTH(CHAIN_LEN)) u_resp (
    .clk   (CLK),
    .rst_n (RN),
    .load  (1'b0),
    .din   ('0),
    .shift (state == SHIFT_OUT),
    .sin   (SO),
    .q     (response)
  );

`ifdef SCAN_CHAIN_DRIVER_PARITY_EN
  // Computed from the value response takes at the final shift edge.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      parity <= 1'b0;
    end else if (state == SHIFT_OUT && last) begin
      parity <= ^{SO, response[CHAIN_LEN-1:1]};
    end
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver with a 16-flop behavioural scan chain
// (mux SE ? SI : D, async RN). inv selects the functional D: hold or ~Q.
module tb_scan_chain_driver;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rn = 1'b0;
  logic         start = 1'b0;
  logic         inv = 1'b0;
  logic [N-1:0] pattern = '0;
  logic         se, si, so, busy, done, parity;
  logic [N-1:0] response;
  logic [N-1:0] chain;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  scan_chain_driver #(.CHAIN_LEN(N)) dut (
    .CLK      (clk),
    .RN       (rn),
    .start    (start),
    .pattern  (pattern),
    .SE       (se),
    .SI       (si),
    .SO       (so),
    .response (response),
    .busy     (busy),
    .done     (done),
    .parity   (parity)
  );

  // chain[15] is the head, chain[0] the tail
  always_ff @(posedge clk or negedge rn) begin
    if (!rn)      chain <= '0;
    else if (se)  chain <= {si, chain[N-1:1]};
    else if (inv) chain <= ~chain;
    else          chain <= chain;
  end
  assign so = chain[0];

  function automatic logic exp_par(input logic [N-1:0] r);
`ifdef SCAN_CHAIN_DRIVER_PARITY_EN
    return ^r;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full sequence started at edge 0; sample k is taken after edge k.
  task automatic run_seq(input logic [N-1:0] pat, input logic mode, input logic [N-1:0] exp_resp);
    logic se_exp, si_exp;
    @(negedge clk);
    pattern = pat;
    inv     = mode;
    start   = 1'b1;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      se_exp = (k <= 15) || (k >= 17 && k <= 32);
      if (k <= 15) si_exp = pat[k];
      else         si_exp = 1'b0;
      chk("se", {31'd0, se}, {31'd0, se_exp});
      chk("si", {31'd0, si}, {31'd0, si_exp});
      chk("done", {31'd0, done}, {31'd0, k == 33});
      chk("busy", {31'd0, busy}, {31'd0, k <= 33});
      if (k == 33) begin
        chk("response", {16'd0, response}, {16'd0, exp_resp});
        chk("parity", {31'd0, parity}, {31'd0, exp_par(exp_resp)});
      end
    end
  endtask

  initial begin
    // Power-on reset
    #12;
    chk("rst_se", {31'd0, se}, 32'd0);
    chk("rst_si", {31'd0, si}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_resp", {16'd0, response}, 32'd0);
    chk("rst_parity", {31'd0, parity}, 32'd0);
    @(negedge clk);
    rn = 1'b1;
    @(negedge clk);

    // Hold capture
    run_seq(16'hA5C3, 1'b0, 16'hA5C3);

    // Reset mid-idle clears response without an edge
    @(negedge clk);
    chk("pre_rst_resp", {16'd0, response}, 32'h0000A5C3);
    #2 rn = 1'b0;
    #1;
    chk("idle_rst_resp", {16'd0, response}, 32'd0);
    chk("idle_rst_se", {31'd0, se}, 32'd0);
    chk("idle_rst_si", {31'd0, si}, 32'd0);
    chk("idle_rst_busy", {31'd0, busy}, 32'd0);
    chk("idle_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rn = 1'b1;
    @(negedge clk);

    // Inverting capture
    run_seq(16'hA5C3, 1'b1, 16'h5A3C);

    // Start re-asserted at edge 5 and held through DONE
    @(negedge clk);
    pattern = 16'h1234;
    inv     = 1'b0;
    start   = 1'b1;
    for (int k = 0; k <= 68; k++) begin
      @(negedge clk);
      if (k == 0)  start = 1'b0;
      if (k == 4)  start = 1'b1;
      if (k == 34) pattern = 16'hBEEF;
      if (k == 35) start = 1'b0;
      chk("ovl_done", {31'd0, done}, {31'd0, (k == 33) || (k == 68)});
      if (k == 33) chk("ovl_resp1", {16'd0, response}, 32'h00001234);
      if (k == 34) chk("ovl_idle_busy", {31'd0, busy}, 32'd0);
      if (k == 35) begin
        chk("ovl_restart_busy", {31'd0, busy}, 32'd1);
        chk("ovl_restart_se", {31'd0, se}, 32'd1);
      end
      if (k == 51) chk("ovl_resp_hold", {16'd0, response}, 32'h00001234);
      if (k == 68) begin
        chk("ovl_resp2", {16'd0, response}, 32'h0000BEEF);
        chk("ovl_parity2", {31'd0, parity}, {31'd0, exp_par(16'hBEEF)});
      end
    end
    @(negedge clk);

    // Reset in the 7th SHIFT_IN cycle
    pattern = 16'h0F0F;
    start   = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("abort_pre_se", {31'd0, se}, 32'd1);
    #2 rn = 1'b0;
    #1;
    chk("abort_se", {31'd0, se}, 32'd0);
    chk("abort_si", {31'd0, si}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_seq(16'hFFFF, 1'b0, 16'hFFFF);

    // Odd-parity pattern
    run_seq(16'h0001, 1'b0, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
